// File: rtl/hex_display_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex_display_scanner: 8-digit multiplexed hex seven-segment scanner        |
// | Optional: HEX_DISP_BLANK_LEADING_ZERO_EN blanks leading-zero digits       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module hex_display_scanner #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] value_i,
  input  logic        load_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int unsigned      c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

  logic [31:0]        value_q, value_d;
  logic [c_div_w-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]         dig_idx_q, dig_idx_d;
  logic [7:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;

  logic               w_tick;
  logic [3:0]         w_nibble;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] enc(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

`ifdef HEX_DISP_BLANK_LEADING_ZERO_EN
  logic [31:0] w_upper;
  logic        w_blank;
`endif

  always_comb begin
    value_d   = load_i ? value_i : value_q;
    w_tick    = (div_cnt_q == c_div_last);
    div_cnt_d = w_tick ? '0 : div_cnt_q + 1'b1;
    dig_idx_d = w_tick ? dig_idx_q + 3'd1 : dig_idx_q;

    w_nibble  = value_q[{dig_idx_q, 2'b00} +: 4];
    an_d      = ~(8'b1 << dig_idx_q);
    seg_d     = enc(w_nibble);

`ifdef HEX_DISP_BLANK_LEADING_ZERO_EN
    // Digit 0 stays lit so an all-zero value still shows a single "0".
    w_upper   = value_q >> {dig_idx_q, 2'b00};
    w_blank   = (dig_idx_q != 3'd0) && (w_upper == 32'd0);
    if (w_blank) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q   <= 32'd0;
      div_cnt_q <= '0;
      dig_idx_q <= 3'd0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
    end else begin
      value_q   <= value_d;
      div_cnt_q <= div_cnt_d;
      dig_idx_q <= dig_idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hex_display_scanner: directed scoreboard bench, CLK_DIV=4 and 1        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_hex_display_scanner;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

`ifdef HEX_DISP_BLANK_LEADING_ZERO_EN
  localparam bit c_blank_on = 1'b1;
`else
  localparam bit c_blank_on = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [31:0] value = 32'd0;

  logic [7:0]  an4, an1;
  logic [6:0]  seg4, seg1;
  logic        dp4, dp1;

  exp_t q4[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  logic [6:0] enc_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_scanner #(.CLK_DIV(4)) u4 (
    .clk_i(clk), .rst_i(rst), .value_i(value), .load_i(load),
    .an_o(an4), .seg_o(seg4), .dp_o(dp4)
  );

  hex_display_scanner #(.CLK_DIV(1)) u1 (
    .clk_i(clk), .rst_i(rst), .value_i(value), .load_i(load),
    .an_o(an1), .seg_o(seg1), .dp_o(dp1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t digit_exp(input int k, input logic [31:0] v);
    exp_t e;
    logic [31:0] upper;
    logic [3:0]  nib;
    upper = v >> (4 * k);
    nib   = upper[3:0];
    if (c_blank_on && (k != 0) && (upper == 32'd0)) begin
      e.an  = 8'hFF;
      e.seg = 7'h7F;
    end else begin
      e.an  = 8'hFF ^ (8'h01 << k);
      e.seg = enc_tab[nib];
    end
    return e;
  endfunction

  // Expected outputs for edges e_from..e_to after reset release, value v shown.
  task automatic push_run(input bit to_u1, input logic [31:0] v,
                          input int e_from, input int e_to, input int div);
    for (int e = e_from; e <= e_to; e++) begin
      if (to_u1) q1.push_back(digit_exp(((e - 1) / div) % 8, v));
      else       q4.push_back(digit_exp(((e - 1) / div) % 8, v));
    end
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("div4_an", an4, e.an);
        chk("div4_seg", {1'b0, seg4}, {1'b0, e.seg});
        chk("div4_dp", {7'd0, dp4}, 8'd1);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("div1_an", an1, e.an);
        chk("div1_seg", {1'b0, seg1}, {1'b0, e.seg});
        chk("div1_dp", {7'd0, dp1}, 8'd1);
      end
    end
  endtask

  // Reset asserted between edges: outputs must clear with no clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_an", an4, 8'hFF);
    chk("rst_async_seg", {1'b0, seg4}, 8'h7F);
    chk("rst_async_dp", {7'd0, dp4}, 8'd1);
    chk("rst_async_an1", an1, 8'hFF);
    @(posedge clk);
    #1;
    chk("rst_hold_an", an4, 8'hFF);
    chk("rst_hold_seg", {1'b0, seg4}, 8'h7F);
    #2 rst = 1'b0;
  endtask

  initial begin
    step(5);

    // Reset then first edge: digit 0 showing "0"
    do_reset();
    q4.push_back('{an: 8'hFE, seg: 7'h40});
    q1.push_back('{an: 8'hFE, seg: 7'h40});
    step(1);

    // Full scan of 12345678 with CLK_DIV=4, including the wrap back to digit 0
    do_reset();
    value = 32'h12345678;
    load  = 1'b1;
    q4.push_back('{an: 8'hFE, seg: 7'h40});
    step(1);
    load = 1'b0;
    push_run(1'b0, 32'h12345678, 2, 36, 4);
    step(35);

    // Load during digit 2: seg changes two edges later, anode holds for the slot
    do_reset();
    value = 32'h12345678;
    load  = 1'b1;
    q4.push_back('{an: 8'hFE, seg: 7'h40});
    step(1);
    load = 1'b0;
    push_run(1'b0, 32'h12345678, 2, 9, 4);
    step(8);
    value = 32'h00000F00;
    load  = 1'b1;
    q4.push_back('{an: 8'hFB, seg: 7'h02});
    step(1);
    load = 1'b0;
    q4.push_back('{an: 8'hFB, seg: 7'h0E});
    q4.push_back('{an: 8'hFB, seg: 7'h0E});
    push_run(1'b0, 32'h00000F00, 13, 14, 4);
    step(4);

    // Leading zeros: A5 then 0 (blanked or lit depending on build)
    do_reset();
    value = 32'h000000A5;
    load  = 1'b1;
    q4.push_back('{an: 8'hFE, seg: 7'h40});
    step(1);
    load = 1'b0;
    push_run(1'b0, 32'h000000A5, 2, 32, 4);
    step(31);
    value = 32'h00000000;
    load  = 1'b1;
    q4.push_back('{an: 8'hFE, seg: 7'h12});
    step(1);
    load = 1'b0;
    push_run(1'b0, 32'h00000000, 34, 40, 4);
    step(7);

    // CLK_DIV=1: a new digit every cycle
    do_reset();
    value = 32'hFEDCBA98;
    load  = 1'b1;
    q1.push_back('{an: 8'hFE, seg: 7'h40});
    step(1);
    load = 1'b0;
    push_run(1'b1, 32'hFEDCBA98, 2, 17, 1);
    step(16);

    checks++;
    assert (q4.size() == 0 && q1.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", q4.size() + q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed 8-digit seven-segment scanner that consumes the 32-bit register value the core exports for display. The value is captured into a shadow register on a load strobe. It is shown as eight hexadecimal nibbles, one digit at a time, with a programmable refresh period. The block sits between the core's display port and the board's common-anode display pins.

## Interface
- CLK_DIV, default 50000: clk_i cycles per digit slot; legal range 1 to 2^20.
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- value_i  in  32  value to display; nibble i appears on digit i.
- load_i  in  1  capture strobe; value_i is sampled on every rising clk_i edge where load_i=1.
- an_o  out  8  digit enables, active-low; at most one bit low at any time.
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low; bit 0 = a.
- dp_o  out  1  decimal point, active-low; constant 1 (off).

## Operation
- **Registers:**
  - value_q (32 b): the shadow register.
  - div_cnt (width max(1, clog2(CLK_DIV))): the prescaler counter.
  - dig_idx (3 b): the current digit index.
  - an_o and seg_o: both registered outputs.
- **Capture:** load_i=1 sets value_q <= value_i. If load_i is held high, value_q tracks value_i every cycle. Nothing else modifies value_q.
- **Prescaler:** div_cnt counts 0 to CLK_DIV-1, then wraps to 0. The cycle where div_cnt==CLK_DIV-1 is a tick. With CLK_DIV=1, every cycle is a tick.
- **Digit counter:** dig_idx increments on each tick and wraps 7 -> 0. It never holds while the clock runs.
- **Output register:** every cycle, an_o <= ~(8'b1 << dig_idx) and seg_o <= enc(value_q[4*dig_idx +: 4]).
- **enc() values (hex, active-low):**
  - 0 -> 40, 1 -> 79, 2 -> 24, 3 -> 30
  - 4 -> 19, 5 -> 12, 6 -> 02, 7 -> 78
  - 8 -> 00, 9 -> 10, A -> 08, b -> 03
  - C -> 46, d -> 21, E -> 06, F -> 0E
- **Load during scan:** a load does not restart the scan. The displayed digit changes to the new nibble one cycle after the capture edge.

## Timing
- **Reset values:** value_q=0, div_cnt=0, dig_idx=0, an_o=8'hFF, seg_o=7'h7F, dp_o=1.
- **First cycle after rst_i deasserts:** the first rising edge loads an_o=8'hFE and seg_o=7'h40 (digit 0 showing "0").
- **Latency:**
  - load_i edge -> value_q: 1 cycle.
  - value_q -> seg_o: 1 further cycle.
  - Total from value_i to pins: 2 edges.
- **Digit advance:** the tick at edge N increments dig_idx at edge N. an_o/seg_o reflect the new digit at edge N+1.
- **Slot length:** each digit is active for exactly CLK_DIV cycles. A full scan takes 8*CLK_DIV cycles.
- **Simultaneous events:**
  - A tick and load_i in the same cycle both take effect.
  - The next output uses the new dig_idx with the new value_q one edge later, with no glitch beyond one cycle.
- **Reset mid-scan:** outputs go to their reset values immediately (asynchronously). The scan restarts at digit 0, and value_q is cleared.

## Configuration
- **HEX_DISP_BLANK_LEADING_ZERO_EN defined:**
  - Digit i (i ≥ 1) is blanked when value_q[31:4*i]==0: an_o=8'hFF and seg_o=7'h7F for that slot.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Slot timing is unchanged.
- **Not defined:** all eight digits are always driven, including leading zeros.

## Test plan
- **Reset:** assert rst_i mid-cycle with CLK_DIV=4 -> an_o=FF, seg_o=7F, dp_o=1 without waiting for a clock edge; the first edge after release gives an_o=FE, seg_o=40.
- **Full scan:** CLK_DIV=4, load 32'h12345678 -> digits 0..7 show 00, 78, 02, 12, 19, 30, 24, 79 in turn, with an_o FE, FD, FB, F7, EF, DF, BF, 7F. Each lasts 4 cycles; digit 0 is shown again at cycle 32.
- **Load mid-slot:** during digit 2, load 32'h00000F00 -> seg_o changes from the old nibble to 0E two edges after load_i is asserted; an_o stays FB until the slot ends.
- **CLK_DIV=1:** load 32'hFEDCBA98 -> the digit changes every cycle: 00, 10, 08, 03, 46, 21, 06, 0E, then repeats.
- **Blanking on:** with the macro defined, load 32'h000000A5 -> digits 0-1 show 12, 08; digits 2-7 show an_o=FF, seg_o=7F. Load 0 -> only digit 0 is lit, showing 40.
- **Blanking off:** with the macro undefined, load 32'h000000A5 -> digits 2-7 show 40 with their anodes active.
